// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the two requester handshakes (Req/Addr/Data in, Gnt out) and the
//   register-file write-port outputs of regfile_write_arbiter.
//   master : the requester side (drives Req*/Addr*/Data*, observes the rest)
//   slave  : the arbiter side
//   Signals:
//     ReqA/AddrA/DataA, ReqB/AddrB/DataB   requests, held until the matching Gnt
//     GntA/GntB                            one-cycle grant pulses
//     Write_Enable/Write_Register/Write_Data  register file write port
//     Busy                                 a write slot is being issued
//     Drop_Count                           saturating count of suppressed R0 writes
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int WORD_LENGTH = 32,
    parameter int NBITS       = 5,
    parameter int CNT_WIDTH   = 8
);
    logic                   ReqA;
    logic [NBITS-1:0]       AddrA;
    logic [WORD_LENGTH-1:0] DataA;
    logic                   GntA;
    logic                   ReqB;
    logic [NBITS-1:0]       AddrB;
    logic [WORD_LENGTH-1:0] DataB;
    logic                   GntB;
    logic                   Write_Enable;
    logic [NBITS-1:0]       Write_Register;
    logic [WORD_LENGTH-1:0] Write_Data;
    logic                   Busy;
    logic [CNT_WIDTH-1:0]   Drop_Count;

    modport master (
        output ReqA, AddrA, DataA, ReqB, AddrB, DataB,
        input  GntA, GntB, Write_Enable, Write_Register, Write_Data, Busy, Drop_Count
    );

    modport slave (
        input  ReqA, AddrA, DataA, ReqB, AddrB, DataB,
        output GntA, GntB, Write_Enable, Write_Register, Write_Data, Busy, Drop_Count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the register file's single write port between requesters A and B
//   with round-robin arbitration and a registered req/gnt handshake. A request
//   sampled at one edge produces Gnt plus the write-port values in the next
//   cycle. With PROTECT_R0 set, writes to register 0 are granted but the write
//   strobe is withheld and Drop_Count (saturating) is incremented.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    regfile_write_arbiter_if.slave (requests in, grants/write port out)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int WORD_LENGTH = 32,
    parameter int NBITS       = 5,
    parameter int PROTECT_R0  = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                 state_q;
    logic                   prio_b_q;      // 1: B wins a tie, 0: A wins a tie
    logic                   gnt_a_q;
    logic                   gnt_b_q;
    logic                   we_q;
    logic [NBITS-1:0]       wreg_q;
    logic [WORD_LENGTH-1:0] wdata_q;
    logic [CNT_WIDTH-1:0]   drop_cnt_q;

    logic                   elig_a_s;
    logic                   elig_b_s;
    logic                   pick_a_s;
    logic                   pick_b_s;
    logic                   any_s;
    logic [NBITS-1:0]       win_addr_s;
    logic [WORD_LENGTH-1:0] win_data_s;
    logic                   suppress_s;
    logic [CNT_WIDTH-1:0]   drop_cnt_d;

    // A requester granted this cycle still shows Req high, so it is masked
    // from the coming arbitration to avoid a double grant of the same write.
    assign elig_a_s = bus.ReqA & ~gnt_a_q;
    assign elig_b_s = bus.ReqB & ~gnt_b_q;
    assign any_s    = elig_a_s | elig_b_s;

    // Round-robin winner selection, R0 suppression and drop counter next value
    always_comb begin
        pick_a_s   = 1'b0;
        pick_b_s   = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (elig_a_s && elig_b_s) begin
            pick_a_s = ~prio_b_q;
            pick_b_s = prio_b_q;
        end else begin
            pick_a_s = elig_a_s;
            pick_b_s = elig_b_s;
        end
        if (pick_b_s) begin
            win_addr_s = bus.AddrB;
            win_data_s = bus.DataB;
        end else begin
            win_addr_s = bus.AddrA;
            win_data_s = bus.DataA;
        end
        suppress_s = (PROTECT_R0 != 0) && (win_addr_s == {NBITS{1'b0}});
        if (any_s && suppress_s && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Write-slot FSM with registered grant and write-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prio_b_q   <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            we_q       <= 1'b0;
            wreg_q     <= {NBITS{1'b0}};
            wdata_q    <= {WORD_LENGTH{1'b0}};
            drop_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE:  state_q <= any_s ? ST_WRITE : ST_IDLE;
                ST_WRITE: state_q <= any_s ? ST_WRITE : ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
            gnt_a_q    <= pick_a_s;
            gnt_b_q    <= pick_b_s;
            drop_cnt_q <= drop_cnt_d;
            if (any_s) begin
                we_q     <= ~suppress_s;
                wreg_q   <= win_addr_s;
                wdata_q  <= win_data_s;
                // Priority moves to whichever requester did not just win
                prio_b_q <= pick_a_s;
            end else begin
                // Idle slot: no strobe, address/data hold their last values
                we_q     <= 1'b0;
                wreg_q   <= wreg_q;
                wdata_q  <= wdata_q;
                prio_b_q <= prio_b_q;
            end
        end
    end

    assign bus.GntA           = gnt_a_q;
    assign bus.GntB           = gnt_b_q;
    assign bus.Write_Enable   = we_q;
    assign bus.Write_Register = wreg_q;
    assign bus.Write_Data     = wdata_q;
    assign bus.Busy           = (state_q == ST_WRITE);
    assign bus.Drop_Count     = drop_cnt_q;

endmodule
